// File: rtl/conv3x3.sv
// conv3x3: 3x3 stride-1 zero-padded multi-channel convolution with bias, one output pixel per clock.
//   clk                in  rising-edge clock
//   rst                in  synchronous active-high reset (clears output bus and sweep index)
//   input_tensor_flat  in  N*C_in*H*W elements, NCHW order
//   weights_flat       in  C_out*C_in*3*3 elements
//   bias_flat          in  C_out elements
//   output_tensor_flat out N*C_out*H*W registered elements, NCHW order
//   CONV3X3_RELU_EN    clamp negative results to 0 before they are registered
module conv3x3 #(
  parameter int DATA_WIDTH   = 32,
  parameter int BATCH_SIZE   = 1,
  parameter int IN_CHANNELS  = 1,
  parameter int OUT_CHANNELS = 1,
  parameter int IN_HEIGHT    = 4,
  parameter int IN_WIDTH     = 4
) (
  input  logic                                                               clk,
  input  logic                                                               rst,
  input  logic [BATCH_SIZE*IN_CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH-1:0]    input_tensor_flat,
  input  logic [OUT_CHANNELS*IN_CHANNELS*9*DATA_WIDTH-1:0]                   weights_flat,
  input  logic [OUT_CHANNELS*DATA_WIDTH-1:0]                                 bias_flat,
  output logic [BATCH_SIZE*OUT_CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH-1:0]   output_tensor_flat
);
  localparam int DW = DATA_WIDTH;
  localparam int CI = IN_CHANNELS;
  localparam int CO = OUT_CHANNELS;
  localparam int H = IN_HEIGHT;
  localparam int W = IN_WIDTH;
  localparam int P = BATCH_SIZE * CO * H * W;
  localparam int WB = W > 1 ? $clog2(W) : 1;
  localparam int HB = H > 1 ? $clog2(H) : 1;
  localparam int CB = CO > 1 ? $clog2(CO) : 1;
  localparam int NB = BATCH_SIZE > 1 ? $clog2(BATCH_SIZE) : 1;
  logic [WB-1:0] r_ow;
  logic [HB-1:0] r_oh;
  logic [CB-1:0] r_oc;
  logic [NB-1:0] r_n;
  logic [DW-1:0] r_mem [P];
  logic signed [DW-1:0] w_acc;
  logic signed [DW-1:0] w_res;
  int w_pix;
  int w_ow;
  int w_oh;
  int w_oc;
  int w_n;
  always_comb begin
    w_ow = int'(r_ow);
    w_oh = int'(r_oh);
    w_oc = int'(r_oc);
    w_n = int'(r_n);
    w_pix = ((w_n * CO + w_oc) * H + w_oh) * W + w_ow;
    w_acc = $signed(bias_flat[w_oc*DW +: DW]);
    for (int c = 0; c < CI; c++)
      for (int kh = 0; kh < 3; kh++)
        for (int kw = 0; kw < 3; kw++)
          if (w_oh + kh >= 1 && w_oh + kh <= H && w_ow + kw >= 1 && w_ow + kw <= W)
            w_acc = w_acc
              + $signed(input_tensor_flat[(((w_n*CI+c)*H+w_oh+kh-1)*W+w_ow+kw-1)*DW +: DW])
              * $signed(weights_flat[(((w_oc*CI+c)*3+kh)*3+kw)*DW +: DW]);
`ifdef CONV3X3_RELU_EN
    w_res = w_acc[DW-1] ? '0 : w_acc;
`else
    w_res = w_acc;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < P; p++) r_mem[p] <= '0;
      r_ow <= '0;
      r_oh <= '0;
      r_oc <= '0;
      r_n <= '0;
    end else begin
      r_mem[w_pix] <= w_res;
      r_ow <= r_ow == WB'(W-1) ? '0 : r_ow + 1'b1;
      if (r_ow == WB'(W-1)) begin
        r_oh <= r_oh == HB'(H-1) ? '0 : r_oh + 1'b1;
        if (r_oh == HB'(H-1)) begin
          r_oc <= r_oc == CB'(CO-1) ? '0 : r_oc + 1'b1;
          if (r_oc == CB'(CO-1)) r_n <= r_n == NB'(BATCH_SIZE-1) ? '0 : r_n + 1'b1;
        end
      end
    end
  end
  for (genvar g = 0; g < P; g++) begin : g_out
    assign output_tensor_flat[g*DW +: DW] = r_mem[g];
  end
endmodule

// File: tb/tb_conv3x3.sv
// tb_conv3x3: directed checks of conv3x3 on a 1x1x4x4 and a 1x2x4x4 (two output channel) configuration.
module tb_conv3x3;
  logic clk = 0;
  logic rst = 1;
  logic [16*32-1:0] in_a;
  logic [9*32-1:0] wt_a;
  logic [31:0] bias_a;
  logic [16*32-1:0] out_a;
  logic [32*32-1:0] in_b;
  logic [36*32-1:0] wt_b;
  logic [2*32-1:0] bias_b;
  logic [32*32-1:0] out_b;
  int total = 0;
  int bad = 0;
  int exp1 [16] = '{10, 18, 24, 18, 27, 45, 54, 39, 51, 81, 90, 63, 42, 66, 72, 50};
  int nb [16] = '{4, 6, 6, 4, 6, 9, 9, 6, 6, 9, 9, 6, 4, 6, 6, 4};
  always #5 clk = ~clk;
  conv3x3 u_a (.clk(clk), .rst(rst), .input_tensor_flat(in_a), .weights_flat(wt_a),
               .bias_flat(bias_a), .output_tensor_flat(out_a));
  conv3x3 #(.IN_CHANNELS(2), .OUT_CHANNELS(2)) u_b (.clk(clk), .rst(rst), .input_tensor_flat(in_b),
               .weights_flat(wt_b), .bias_flat(bias_b), .output_tensor_flat(out_b));
  task automatic check(input string tag, input int i, input logic signed [31:0] o, input logic signed [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s[%0d] got=%0d exp=%0d", tag, i, o, e);
    end
  endtask
  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic case1_inputs();
    for (int i = 0; i < 16; i++) in_a[i*32 +: 32] = i;
    for (int i = 0; i < 9; i++) wt_a[i*32 +: 32] = 1;
    bias_a = 0;
  endtask
  initial begin
    logic signed [31:0] e;
    case1_inputs();
    for (int i = 0; i < 32; i++) in_b[i*32 +: 32] = i < 16 ? 1 : 2;
    for (int i = 0; i < 36; i++) wt_b[i*32 +: 32] = 1;
    bias_b = {32'd1, 32'd0};
    clocks(2);
    for (int i = 0; i < 16; i++) check("reset", i, out_a[i*32 +: 32], 0);
    rst = 0;
    clocks(1);
    check("first_edge", 0, out_a[0 +: 32], 10);
    check("first_edge", 1, out_a[32 +: 32], 0);
    clocks(15);
    for (int i = 0; i < 16; i++) check("case1", i, out_a[i*32 +: 32], exp1[i]);
    bias_a = 5;
    clocks(16);
    for (int i = 0; i < 16; i++) check("bias5", i, out_a[i*32 +: 32], exp1[i] + 5);
    bias_a = 0;
    wt_a = '0;
    wt_a[4*32 +: 32] = 1;
    clocks(16);
    for (int i = 0; i < 16; i++) check("center", i, out_a[i*32 +: 32], i);
    in_a = '0;
    in_a[5*32 +: 32] = 32'h7fffffff;
    wt_a[4*32 +: 32] = 2;
    clocks(16);
`ifdef CONV3X3_RELU_EN
    check("wrap", 5, out_a[5*32 +: 32], 0);
`else
    check("wrap", 5, out_a[5*32 +: 32], 32'hfffffffe);
`endif
    check("wrap", 6, out_a[6*32 +: 32], 0);
    for (int i = 0; i < 16; i++) in_a[i*32 +: 32] = 1;
    for (int i = 0; i < 9; i++) wt_a[i*32 +: 32] = -1;
    clocks(16);
    for (int i = 0; i < 16; i++) begin
`ifdef CONV3X3_RELU_EN
      e = 0;
`else
      e = -nb[i];
`endif
      check("neg", i, out_a[i*32 +: 32], e);
    end
    case1_inputs();
    clocks(8);
    rst = 1;
    clocks(1);
    for (int i = 0; i < 16; i++) check("mid_reset", i, out_a[i*32 +: 32], 0);
    rst = 0;
    clocks(1);
    check("restart", 0, out_a[0 +: 32], 10);
    check("restart", 1, out_a[32 +: 32], 0);
    clocks(15);
    for (int i = 0; i < 16; i++) check("recover", i, out_a[i*32 +: 32], exp1[i]);
    clocks(32);
    for (int i = 0; i < 16; i++) begin
      check("multi_oc0", i, out_b[i*32 +: 32], 3 * nb[i]);
      check("multi_oc1", i, out_b[(16+i)*32 +: 32], 3 * nb[i] + 1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
